// File: rtl/program_mem_responder_if.sv
// Fetch-bus and program-loader signal bundle for program_mem_responder.
// master: CPU fetch side + load source (drives addr and load_*); slave: the responder.
// checksum is present only when MEM_CHECKSUM_EN is defined.
interface program_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [15:0]     addr;        // CPU read address
    logic [7:0]      dout;        // registered read data (CPU din)
    logic            load_start;  // begin a load (honoured in IDLE only)
    logic            load_valid;  // load_data valid
    logic [7:0]      load_data;   // byte to write
    logic            load_last;   // final byte of the load (with load_valid)
    logic            load_ready;  // loader accepts a byte this cycle
    logic            load_done;   // one-cycle pulse at end of load
    logic            cpu_hold;    // hold CPU in reset while high
    logic [ADDR_W:0] load_count;  // bytes accepted in current/last load
`ifdef MEM_CHECKSUM_EN
    logic [7:0]      checksum;    // mod-256 sum of loaded bytes

    modport master (
        output addr, load_start, load_valid, load_data, load_last,
        input  dout, load_ready, load_done, cpu_hold, load_count, checksum
    );
    modport slave (
        input  addr, load_start, load_valid, load_data, load_last,
        output dout, load_ready, load_done, cpu_hold, load_count, checksum
    );
`else
    modport master (
        output addr, load_start, load_valid, load_data, load_last,
        input  dout, load_ready, load_done, cpu_hold, load_count
    );
    modport slave (
        input  addr, load_start, load_valid, load_data, load_last,
        output dout, load_ready, load_done, cpu_hold, load_count
    );
`endif
endinterface

// File: rtl/program_mem_responder.sv
// Program memory responder: serves CPU fetches (byte at addr -> dout) and fills memory from a
//   byte-serial valid/ready loader, holding the CPU in reset while a load is in progress.
// Latency: dout is registered, 1 cycle after addr. Loader accepts one byte per cycle in LOAD only.
// Ports: clk, reset (async, active-high), bus (program_mem_responder_if.slave).
// Optional feature macro: MEM_CHECKSUM_EN adds a running mod-256 checksum of loaded bytes.
module program_mem_responder #(
    parameter int         ADDR_W    = 8,
    parameter int         LOAD_BASE = 0,
    parameter logic [7:0] FILL_BYTE = 8'hEA
) (
    input  logic                     clk,
    input  logic                     reset,
    program_mem_responder_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wr_idx;
    logic            beat;
    logic            in_range;
    logic [7:0]      dout_q;
    logic            load_ready_q;
    logic            load_done_q;
    logic            cpu_hold_q;
    logic [ADDR_W:0] load_count_q;
`ifdef MEM_CHECKSUM_EN
    logic [7:0]      checksum_q;
`endif

    assign wr_idx   = BASE + ptr;
    // load_ready_q is only high in LOAD and drops asynchronously on reset, so it alone
    // gates memory writes and keeps them off during reset.
    assign beat     = bus.load_valid && load_ready_q;
    assign in_range = (bus.addr[15:ADDR_W] == '0);

    // Memory has no reset: program contents must survive a CPU/system reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dout_q       <= FILL_BYTE;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            cpu_hold_q   <= 1'b0;
            load_count_q <= '0;
            ptr          <= '0;
`ifdef MEM_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            // Memory is being rewritten outside IDLE, so fetches see the fill opcode.
            dout_q <= (state == IDLE && in_range) ? mem[bus.addr[ADDR_W-1:0]] : FILL_BYTE;

            case (state)
                IDLE: begin
                    load_done_q <= 1'b0;
                    if (bus.load_start) begin
                        state        <= LOAD;
                        ptr          <= '0;
                        load_count_q <= '0;
                        load_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
`ifdef MEM_CHECKSUM_EN
                        checksum_q   <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (beat) begin
                        load_count_q <= load_count_q + (ADDR_W+1)'(1);
`ifdef MEM_CHECKSUM_EN
                        checksum_q   <= checksum_q + bus.load_data;
`endif
                        // Writing the top index ends the load so ptr never wraps.
                        if (bus.load_last || wr_idx == LAST_IDX) begin
                            state        <= DONE;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    load_done_q <= 1'b0;
                    cpu_hold_q  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    load_ready_q <= 1'b0;
                    load_done_q  <= 1'b0;
                    cpu_hold_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_done  = load_done_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_count = load_count_q;
`ifdef MEM_CHECKSUM_EN
    assign bus.checksum   = checksum_q;
`endif
endmodule
